// File: rtl/data_packet_receiver_pkg.sv
// ============================================================================
// Module : data_packet_receiver_pkg
// Brief  : Link-level types and constants shared by the 4-line packet receiver
//          (packet layout, tile encoding, line framing, receive FSM states).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_packet_receiver_pkg;

    localparam int NUM_LINES         = 4;
    localparam int PAD_BITS          = 9;
    localparam int PAYLOAD_BITS      = 209;
    localparam int FRAME_BITS        = PAD_BITS + PAYLOAD_BITS;
    localparam int ENC_DATA_BITS     = NUM_LINES * PAYLOAD_BITS;
    localparam int RX_TIMEOUT        = 255;
    localparam int RX_TIMEOUT_CYCLES = RX_TIMEOUT;
    localparam int GBG_BITS          = 4;
    localparam int SEQ_BITS          = 4;

    localparam int NEXT_PIECES_COUNT = 6;
    localparam int PLAYFIELD_ROWS    = 20;
    localparam int PLAYFIELD_COLS    = 10;

    typedef logic [3:0] tile_type_t;
    localparam tile_type_t TILE_BLANK = 4'd0;
    localparam tile_type_t TILE_I     = 4'd1;
    localparam tile_type_t TILE_O     = 4'd2;
    localparam tile_type_t TILE_T     = 4'd3;
    localparam tile_type_t TILE_S     = 4'd4;
    localparam tile_type_t TILE_Z     = 4'd5;
    localparam tile_type_t TILE_J     = 4'd6;
    localparam tile_type_t TILE_L     = 4'd7;

    // Field order is the wire order: seq leads line 0, playfield tail ends line 3.
    typedef struct packed {
        logic [SEQ_BITS-1:0]                                      seq;
        logic [GBG_BITS-1:0]                                      garbage;
        tile_type_t                                               hold;
        tile_type_t [NEXT_PIECES_COUNT-1:0]                       piece_queue;
        tile_type_t [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0]      playfield;
    } data_pkt_t;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE    = 3'd0;
    localparam rx_state_t RX_RECV    = 3'd1;
    localparam rx_state_t RX_CHECK   = 3'd2;
    localparam rx_state_t RX_DELIVER = 3'd3;
    localparam rx_state_t RX_REACK   = 3'd4;
    localparam rx_state_t RX_DROP    = 3'd5;

    // The single seq bit is replicated four times; anything mixed is corrupt.
    function automatic logic seq_valid(input logic [SEQ_BITS-1:0] seq);
        return (seq == 4'b0000) || (seq == 4'b1111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_packet_receiver_if.sv
// ============================================================================
// Module : data_packet_receiver_if
// Brief  : Serial link inputs and opponent-view / ACK outputs of the receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_packet_receiver_if;
    import data_packet_receiver_pkg::*;

    logic                                                 serial_in_0;
    logic                                                 serial_in_1;
    logic                                                 serial_in_2;
    logic                                                 serial_in_3;
    logic                                                 update_opponent;
    logic [GBG_BITS-1:0]                                  garbage_rx;
    tile_type_t                                           hold_rx;
    tile_type_t [NEXT_PIECES_COUNT-1:0]                   piece_queue_rx;
    tile_type_t [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0]  playfield_rx;
    logic                                                 send_ready_ACK;
    logic                                                 ack_seqNum;
    logic                                                 pkt_dropped;

    modport master (
        output serial_in_0, serial_in_1, serial_in_2, serial_in_3,
        input  update_opponent, garbage_rx, hold_rx, piece_queue_rx, playfield_rx,
        input  send_ready_ACK, ack_seqNum, pkt_dropped
    );

    modport slave (
        input  serial_in_0, serial_in_1, serial_in_2, serial_in_3,
        output update_opponent, garbage_rx, hold_rx, piece_queue_rx, playfield_rx,
        output send_ready_ACK, ack_seqNum, pkt_dropped
    );

endinterface

`default_nettype wire

// File: rtl/data_packet_receiver_serial_line_rx.sv
// ============================================================================
// Module : serial_line_rx
// Brief  : One data line: start-bit detect, FRAME_BITS MSB-first shift-in,
//          sticky done flag held until a synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_line_rx
    import data_packet_receiver_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  serial_in,
    output logic                  start,
    output logic                  done,
    output logic [FRAME_BITS-1:0] frame
);

    logic                  r_active;
    logic                  r_done;
    logic [7:0]            r_cnt;
    logic [FRAME_BITS-1:0] r_shift;

    // A finished line ignores further start bits until the packet is retired.
    assign start = !clr && !r_active && !r_done && serial_in;
    assign done  = r_done;
    assign frame = r_shift;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= 8'd0;
            r_shift  <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= 8'd0;
        end else if (r_active) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], serial_in};
            if (r_cnt == 8'(FRAME_BITS - 1)) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_packet_receiver.sv
// ============================================================================
// Module : data_packet_receiver
// Brief  : Reassembles a 4-line data packet, validates framing and seq, then
//          delivers opponent fields and requests an ACK. Option: RX_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_packet_receiver
    import data_packet_receiver_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_active,
    data_packet_receiver_if.slave link
`ifdef RX_STATS_EN
    ,
    output logic [15:0]           rx_good_cnt,
    output logic [15:0]           rx_dup_cnt,
    output logic [15:0]           rx_drop_cnt
`endif
);

    logic [NUM_LINES-1:0]     w_serial;
    logic [NUM_LINES-1:0]     w_start;
    logic [NUM_LINES-1:0]     w_done;
    logic [NUM_LINES-1:0]     w_pad_ok;
    logic [FRAME_BITS-1:0]    w_frame [NUM_LINES];
    logic [ENC_DATA_BITS-1:0] w_pkt_bits;
    data_pkt_t                w_pkt;
    logic                     w_clr;
    logic                     w_s;

    rx_state_t                r_state;
    logic [7:0]               r_timer;
    logic                     r_expected;
    logic                     r_update;
    logic                     r_ack_pulse;
    logic                     r_ack_seq;
    logic                     r_dropped;
    logic [GBG_BITS-1:0]      r_garbage;
    tile_type_t               r_hold;
    tile_type_t [NEXT_PIECES_COUNT-1:0]              r_pq;
    tile_type_t [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0] r_pf;

    assign w_serial = {link.serial_in_3, link.serial_in_2, link.serial_in_1, link.serial_in_0};

    // Lines are retired in the one-cycle outcome states and while the game is idle.
    assign w_clr = !game_active || (r_state == RX_DELIVER) ||
                   (r_state == RX_REACK) || (r_state == RX_DROP);

    generate
        for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
            serial_line_rx u_line (
                .clk       (clk),
                .rst       (rst),
                .clr       (w_clr),
                .serial_in (w_serial[k]),
                .start     (w_start[k]),
                .done      (w_done[k]),
                .frame     (w_frame[k])
            );
            assign w_pad_ok[k] = (w_frame[k][FRAME_BITS-1 -: PAD_BITS] == '0);
            assign w_pkt_bits[ENC_DATA_BITS-1-PAYLOAD_BITS*k -: PAYLOAD_BITS] =
                w_frame[k][PAYLOAD_BITS-1:0];
        end
    endgenerate

    assign w_pkt = w_pkt_bits;
    assign w_s   = w_pkt.seq[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_timer     <= 8'd0;
            r_expected  <= 1'b0;
            r_update    <= 1'b0;
            r_ack_pulse <= 1'b0;
            r_ack_seq   <= 1'b0;
            r_dropped   <= 1'b0;
            r_garbage   <= '0;
            r_hold      <= TILE_BLANK;
            r_pq        <= '0;
            r_pf        <= '0;
        end else begin
            r_update    <= 1'b0;
            r_ack_pulse <= 1'b0;
            r_dropped   <= 1'b0;
            if (!game_active) begin
                r_state <= RX_IDLE;
                r_timer <= 8'd0;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        if (|w_start) begin
                            r_state <= RX_RECV;
                            r_timer <= 8'd0;
                        end
                    end
                    RX_RECV: begin
                        r_timer <= r_timer + 8'd1;
                        // Compare on the next count so the drop pulse lands
                        // exactly RX_TIMEOUT cycles after the first start bit.
                        if (&w_done) begin
                            r_state <= RX_CHECK;
                        end else if (r_timer == 8'(RX_TIMEOUT - 1)) begin
                            r_state   <= RX_DROP;
                            r_dropped <= 1'b1;
                        end
                    end
                    RX_CHECK: begin
                        if (!(&w_pad_ok) || !seq_valid(w_pkt.seq)) begin
                            r_state   <= RX_DROP;
                            r_dropped <= 1'b1;
                        end else if (w_s == r_expected) begin
                            r_state     <= RX_DELIVER;
                            r_update    <= 1'b1;
                            r_ack_pulse <= 1'b1;
                            r_ack_seq   <= ~w_s;
                            r_expected  <= ~r_expected;
                            r_garbage   <= w_pkt.garbage;
                            r_hold      <= w_pkt.hold;
                            r_pq        <= w_pkt.piece_queue;
                            r_pf        <= w_pkt.playfield;
                        end else begin
                            // Duplicate: the sender missed our ACK, so repeat it.
                            r_state     <= RX_REACK;
                            r_ack_pulse <= 1'b1;
                            r_ack_seq   <= ~w_s;
                        end
                    end
                    RX_DELIVER, RX_REACK, RX_DROP: r_state <= RX_IDLE;
                    default:                       r_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign link.update_opponent = r_update;
    assign link.garbage_rx      = r_garbage;
    assign link.hold_rx         = r_hold;
    assign link.piece_queue_rx  = r_pq;
    assign link.playfield_rx    = r_pf;
    assign link.send_ready_ACK  = r_ack_pulse;
    assign link.ack_seqNum      = r_ack_seq;
    assign link.pkt_dropped     = r_dropped;

`ifdef RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_dup_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt <= 16'd0;
            r_dup_cnt  <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (r_state == RX_DELIVER && r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
            if (r_state == RX_REACK   && r_dup_cnt  != 16'hFFFF) r_dup_cnt  <= r_dup_cnt  + 16'd1;
            if (r_state == RX_DROP    && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign rx_good_cnt = r_good_cnt;
    assign rx_dup_cnt  = r_dup_cnt;
    assign rx_drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_packet_receiver.sv
// ============================================================================
// Module : tb_data_packet_receiver
// Brief  : Self-checking bench for data_packet_receiver (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_packet_receiver;
    import data_packet_receiver_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic game_active;

    data_packet_receiver_if link();

    data_packet_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .game_active (game_active),
        .link        (link)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Pulse monitor: sole writer of these event records.
    int   upd_cnt = 0, ack_cnt = 0, drop_cnt = 0, excl_viol = 0;
    int   upd_cyc = 0, ack_cyc = 0, drop_cyc = 0;
    logic ack_val = 1'b0;

    always @(negedge clk) begin
        if (link.update_opponent) begin upd_cnt++; upd_cyc = cyc; end
        if (link.send_ready_ACK) begin ack_cnt++; ack_cyc = cyc; ack_val = link.ack_seqNum; end
        if (link.pkt_dropped) begin drop_cnt++; drop_cyc = cyc; end
        if ((link.update_opponent || link.send_ready_ACK) && link.pkt_dropped) excl_viol++;
    end

    // Reference state: last delivered {garbage, hold, queue, playfield} and expected seq.
    logic [831:0] m_fields;
    logic         m_exp;
    string        cur_tag;
    int           b_upd, b_ack, b_drop, b_excl;

    typedef struct {
        logic [3:0] seq;
        logic [3:0] gbg;
        logic [3:0] hold;
        int         bad_line;
        int         o1, o2, o3;
        int         kind;      // 0 deliver, 1 re-ack, 2 drop
        logic       ack;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [831:0] act, input logic [831:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s actual=%0h required=%0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [823:0] rand_body();
        logic [831:0] v;
        for (int i = 0; i < 26; i++) v[i*32 +: 32] = $urandom;
        return v[823:0];
    endfunction

    function automatic int predict(input logic [3:0] seq, input bit pad_ok, input logic expd);
        if (!pad_ok || !(seq == 4'h0 || seq == 4'hF)) return 2;
        if (seq[0] == expd) return 0;
        return 1;
    endfunction

    task automatic set_lines(input logic [3:0] b);
        link.serial_in_0 = b[0];
        link.serial_in_1 = b[1];
        link.serial_in_2 = b[2];
        link.serial_in_3 = b[3];
    endtask

    task automatic drive_lines(input logic [835:0] pkt, input logic [3:0][8:0] pad,
                               input int o0, input int o1, input int o2, input int o3,
                               input logic [3:0] en, input int stop_at,
                               output int first_e, output int last_e);
        logic [218:0] st [4];
        int           off [4];
        int           len, lo, hi;
        logic [3:0]   b;
        off = '{o0, o1, o2, o3};
        lo = 1000; hi = 0;
        for (int k = 0; k < 4; k++) begin
            st[k] = {1'b1, pad[k], pkt[835-209*k -: 209]};
            if (en[k]) begin
                if (off[k] < lo) lo = off[k];
                if (off[k] > hi) hi = off[k];
            end
        end
        len = hi + 219;
        if (stop_at > 0 && stop_at < len) len = stop_at;
        first_e = -1;
        last_e  = -1;
        for (int t = 0; t < len; t++) begin
            for (int k = 0; k < 4; k++)
                b[k] = (en[k] && t >= off[k] && t < off[k] + 219) ? st[k][218-(t-off[k])] : 1'b0;
            set_lines(b);
            step();
            if (t == lo) first_e = cyc;
            if (t == hi + 218) last_e = cyc;
        end
        set_lines(4'b0000);
    endtask

    task automatic mark();
        b_upd = upd_cnt; b_ack = ack_cnt; b_drop = drop_cnt; b_excl = excl_viol;
    endtask

    task automatic wait_result(input int budget);
        int n = 0;
        while ((upd_cnt - b_upd) + (ack_cnt - b_ack) + (drop_cnt - b_drop) == 0 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s/no_pulse actual=none required=pulse within %0d cycles", cur_tag, budget);
        end
        repeat (4) step();
    endtask

    task automatic check_result(input int kind, input logic ack_exp, input logic [835:0] pkt,
                                input int first_e, input int last_e, input bit tmo);
        chk("upd_cnt",  upd_cnt - b_upd,   (kind == 0) ? 1 : 0);
        chk("ack_cnt",  ack_cnt - b_ack,   (kind != 2) ? 1 : 0);
        chk("drop_cnt", drop_cnt - b_drop, (kind == 2) ? 1 : 0);
        chk("exclusive", excl_viol - b_excl, 0);
        if (kind == 0) begin
            chk("upd_cycle", upd_cyc, last_e + 2);
            m_fields = pkt[831:0];
            m_exp    = ~m_exp;
        end
        if (kind != 2) begin
            chk("ack_cycle", ack_cyc, last_e + 2);
            chk("ack_seq", ack_val, ack_exp);
            chk("ack_seq_hold", link.ack_seqNum, ack_exp);
        end
        if (kind == 2) chk("drop_cycle", drop_cyc, tmo ? first_e + RX_TIMEOUT : last_e + 2);
        chk("garbage", link.garbage_rx, m_fields[831:828]);
        chk("hold", link.hold_rx, m_fields[827:824]);
        chk("queue", link.piece_queue_rx, m_fields[823:800]);
        chk("playfield", link.playfield_rx, m_fields[799:0]);
        chk("pf_7_3", link.playfield_rx[7][3], m_fields[4*PLAYFIELD_COLS*7 + 4*3 +: 4]);
        chk("queue_2", link.piece_queue_rx[2], m_fields[800 + 4*2 +: 4]);
    endtask

    task automatic run_txn(input string tag, input logic [835:0] pkt, input logic [3:0][8:0] pad,
                           input int o0, input int o1, input int o2, input int o3,
                           input logic [3:0] en, input int kind, input logic ack_exp, input bit tmo);
        int fe, le;
        cur_tag = tag;
        mark();
        drive_lines(pkt, pad, o0, o1, o2, o3, en, 0, fe, le);
        wait_result(300);
        check_result(kind, ack_exp, pkt, fe, le, tmo);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [835:0]     pkt;
        logic [823:0]     body;
        logic [3:0][8:0]  pad;
        logic [3:0]       seq;
        int               fe, le, kind;
        bit               pad_ok;

        tbl[0] = '{4'h0, 4'd3,  TILE_T, 4, 0, 0, 0,  0, 1'b1};
        tbl[1] = '{4'h0, 4'd3,  TILE_T, 4, 0, 0, 0,  1, 1'b1};
        tbl[2] = '{4'h5, 4'd1,  TILE_O, 4, 0, 0, 0,  2, 1'b0};
        tbl[3] = '{4'hF, 4'd9,  TILE_L, 4, 0, 5, 17, 0, 1'b0};
        tbl[4] = '{4'hF, 4'd2,  TILE_S, 2, 3, 1, 0,  2, 1'b0};
        tbl[5] = '{4'h0, 4'd15, TILE_I, 4, 0, 0, 0,  0, 1'b1};

        rst = 1'b1;
        game_active = 1'b0;
        set_lines(4'b0000);
        repeat (3) step();
        cur_tag = "reset";
        chk("update_opponent", link.update_opponent, 0);
        chk("send_ready_ACK", link.send_ready_ACK, 0);
        chk("pkt_dropped", link.pkt_dropped, 0);
        chk("ack_seqNum", link.ack_seqNum, 0);
        chk("garbage", link.garbage_rx, 0);
        chk("hold", link.hold_rx, TILE_BLANK);
        chk("playfield", link.playfield_rx, 0);
        rst = 1'b0;
        game_active = 1'b1;
        m_exp = 1'b0;
        m_fields = '0;
        repeat (2) step();

        body = '0;
        for (int i = 0; i < 6; i++) begin
            if (i != 1) body = rand_body();
            pkt = {tbl[i].seq, tbl[i].gbg, tbl[i].hold, body};
            pad = '0;
            if (tbl[i].bad_line < 4) pad[tbl[i].bad_line] = 9'h040;
            run_txn($sformatf("vec%0d", i), pkt, pad, 0, tbl[i].o1, tbl[i].o2, tbl[i].o3,
                    4'b1111, tbl[i].kind, tbl[i].ack, 1'b0);
        end

        // Partial packet abandoned by game_active low; only the next one lands.
        cur_tag = "abort";
        mark();
        pkt = {4'hF, 4'd6, TILE_Z, rand_body()};
        drive_lines(pkt, '0, 0, 0, 0, 0, 4'b1111, 100, fe, le);
        game_active = 1'b0;
        repeat (3) step();
        game_active = 1'b1;
        repeat (3) step();
        chk("upd_cnt", upd_cnt - b_upd, 0);
        chk("ack_cnt", ack_cnt - b_ack, 0);
        chk("drop_cnt", drop_cnt - b_drop, 0);
        pkt = {4'hF, 4'd5, TILE_J, rand_body()};
        run_txn("after_abort", pkt, '0, 0, 0, 0, 0, 4'b1111, 0, 1'b0, 1'b0);

        // Line 3 silent: timeout drop.
        pkt = {4'h0, 4'd7, TILE_T, rand_body()};
        run_txn("timeout", pkt, '0, 0, 0, 0, 0, 4'b0111, 2, 1'b0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0:       seq = 4'h0;
                1:       seq = 4'hF;
                2:       seq = 4'(m_exp ? 4'h0 : 4'hF);
                default: seq = 4'($urandom);
            endcase
            pad = '0;
            pad_ok = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                pad[$urandom_range(0, 3)] = 9'(1 << $urandom_range(0, 8));
                pad_ok = 1'b0;
            end
            pkt = {seq, 4'($urandom), 4'($urandom_range(0, 7)), rand_body()};
            kind = predict(seq, pad_ok, m_exp);
            run_txn($sformatf("rand%0d", r), pkt, pad,
                    $urandom_range(0, 20), $urandom_range(0, 20),
                    $urandom_range(0, 20), $urandom_range(0, 20),
                    4'b1111, kind, ~seq[0], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
